// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_pkg
//  Description : Shared types for the MEM-stage load/store unit: FSM state
//                encoding, funct3 access codes, access size/sign decode.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_stage_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    typedef struct packed {
        lsu_size_e size;
        logic      unsigned_ld;
    } lsu_access_t;

    // Load encodings; SB/SH/SW share the LB/LH/LW codes.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Any code outside the legal set for the access direction falls back to
    // a full word. 100/101 only mean something for loads.
    function automatic lsu_access_t decode_access(input logic [2:0] f3,
                                                  input logic       is_store);
        lsu_access_t acc;
        acc.size        = SZ_W;
        acc.unsigned_ld = 1'b0;
        case (f3)
            F3_LB:  acc.size = SZ_B;
            F3_LH:  acc.size = SZ_H;
            F3_LBU: if (!is_store) begin
                        acc.size        = SZ_B;
                        acc.unsigned_ld = 1'b1;
                    end
            F3_LHU: if (!is_store) begin
                        acc.size        = SZ_H;
                        acc.unsigned_ld = 1'b1;
                    end
            default: ;
        endcase
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_if
//  Description : Valid/ready data-bus port between the MEM-stage LSU (master)
//                and the external bus adapter (slave). Requests are held
//                while valid & ~ready; responses are always accepted.
//  Ports       : dbus_req_valid/ready, dbus_addr, dbus_we, dbus_wstrb,
//                dbus_wdata (request); dbus_rsp_valid, dbus_rsp_err,
//                dbus_rdata (response).
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic [31:0] dbus_addr;
    logic        dbus_we;
    logic [3:0]  dbus_wstrb;
    logic [31:0] dbus_wdata;
    logic        dbus_rsp_valid;
    logic        dbus_rsp_err;
    logic [31:0] dbus_rdata;

    modport master (
        output dbus_req_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
        input  dbus_req_ready, dbus_rsp_valid, dbus_rsp_err, dbus_rdata
    );

    modport slave (
        input  dbus_req_valid, dbus_addr, dbus_we, dbus_wstrb, dbus_wdata,
        output dbus_req_ready, dbus_rsp_valid, dbus_rsp_err, dbus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu_align
//  Description : Combinational lane logic. Builds byte strobes and
//                lane-replicated write data for stores, and selects plus
//                sign/zero-extends the addressed byte/half for loads.
//  Ports       : i_size, i_unsigned, i_addr_lo  access shape
//                i_store_data, i_rdata           raw data in
//                o_wstrb, o_wdata, o_load_data   lane-adjusted data out
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  lsu_size_e   i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store lanes: data is replicated so every enabled lane sees the value.
    always_comb begin
        o_wstrb = 4'hF;
        o_wdata = i_store_data;
        case (i_size)
            SZ_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SZ_H: begin
                // Only a[1] picks the half; a[0] is ignored when unaligned.
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = i_rdata;
        case (i_size)
            SZ_B: o_load_data = i_unsigned ? {24'd0, w_byte}
                                           : {{24{w_byte[7]}}, w_byte};
            SZ_H: o_load_data = i_unsigned ? {16'd0, w_half}
                                           : {{16{w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : MEM stage of the 5-stage RV32I pipeline. Issues loads and
//                stores on the valid/ready data bus, stalls the upstream
//                pipe while an access is outstanding and owns MEM/WB.
//  Parameters  : RSP_TIMEOUT  cycles allowed in REQ+WAIT before a bus error
//                             (0 disables the timeout)
//  Macros      : MEM_LSU_MISALIGN_TRAP_EN  misaligned half/word accesses are
//                trapped (bus_err, no bus cycle, no stall) instead of
//                having their low address bits ignored.
//  Ports       : clk, rst                     clock, sync active-high reset
//                mem_*                        EX/MEM slot inputs
//                mem_fwd_data, mem_stall      forwarding source, pipe freeze
//                dbus (master modport)        data-bus request/response
//                wb_reg_write, wb_rd, wb_data MEM/WB register
//                bus_err                      1-cycle error pulse
//  Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int RSP_TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic [31:0]     mem_alu_out,
    input  logic [31:0]     mem_wdata,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      mem_funct3,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    output logic [31:0]     mem_fwd_data,
    output logic            mem_stall,
    mem_stage_lsu_if.master dbus,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [31:0]     wb_data,
    output logic            bus_err
);

    localparam int CNT_W = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;

    lsu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_wb_we;
    logic [4:0]         r_wb_rd;
    logic [31:0]        r_wb_data;
    logic               r_bus_err;

    lsu_access_t        w_acc;
    logic               w_mem_op;
    logic               w_is_store;
    logic               w_misalign;
    logic               w_start;
    logic               w_trap;
    logic               w_busy;
    logic               w_rsp;
    logic               w_rsp_err;
    logic               w_tmo_hit;
    logic               w_timeout;
    logic [3:0]         w_strb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load_data;

    // A store wins if both read and write are flagged.
    assign w_mem_op   = mem_valid & (mem_read | mem_write);
    assign w_is_store = mem_write;
    assign w_acc      = decode_access(mem_funct3, w_is_store);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((w_acc.size == SZ_H) && mem_alu_out[0]) ||
                        ((w_acc.size == SZ_W) && (mem_alu_out[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_start   = (r_state == IDLE) && w_mem_op && !w_misalign;
    assign w_trap    = (r_state == IDLE) && w_mem_op &&  w_misalign;
    assign w_busy    = (r_state == REQ) || (r_state == WAIT);
    assign w_rsp     = (r_state == WAIT) && dbus.dbus_rsp_valid;
    assign w_rsp_err = w_rsp && dbus.dbus_rsp_err;

    // A real response in the deadline cycle beats the timeout. Once the
    // timeout fires the stall drops in the same cycle so the faulting
    // instruction leaves EX/MEM instead of being reissued from IDLE.
    assign w_tmo_hit = (RSP_TIMEOUT != 0) && (r_cnt == CNT_W'(RSP_TIMEOUT));
    assign w_timeout = w_busy && w_tmo_hit && !w_rsp;

    assign mem_stall = w_start || (w_busy && !w_rsp && !w_timeout);

    mem_stage_lsu_align u_align (
        .i_size       (w_acc.size),
        .i_unsigned   (w_acc.unsigned_ld),
        .i_addr_lo    (mem_alu_out[1:0]),
        .i_store_data (mem_wdata),
        .i_rdata      (dbus.dbus_rdata),
        .o_wstrb      (w_strb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    // Request fields come straight from EX/MEM, which the stall holds
    // stable for as long as the request is pending.
    assign dbus.dbus_req_valid = (r_state == REQ);
    assign dbus.dbus_addr      = {mem_alu_out[31:2], 2'b00};
    assign dbus.dbus_we        = w_is_store;
    assign dbus.dbus_wstrb     = w_is_store ? w_strb : 4'h0;
    assign dbus.dbus_wdata     = w_wdata;

    assign mem_fwd_data = mem_alu_out;

    // FSM and MEM/WB register. wb_reg_write defaults to a bubble; only a
    // non-memory op leaving IDLE or a clean load response writes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_wb_we   <= 1'b0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_wb_we   <= 1'b0;
            r_bus_err <= w_timeout || w_rsp_err || w_trap;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= REQ;
                        r_cnt   <= '0;
                    end else if (!w_trap) begin
                        r_wb_we   <= mem_valid & mem_reg_write;
                        r_wb_rd   <= mem_rd;
                        r_wb_data <= mem_alu_out;
                    end
                end
                REQ: begin
                    if (w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        if (dbus.dbus_req_ready) begin
                            r_state <= WAIT;
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (w_rsp) begin
                        r_state <= IDLE;
                        if (!dbus.dbus_rsp_err && !w_is_store) begin
                            r_wb_we   <= mem_valid & mem_reg_write;
                            r_wb_rd   <= mem_rd;
                            r_wb_data <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_reg_write = r_wb_we;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Self-checking bench for mem_stage_lsu. Each instruction is
//                held in the EX/MEM slot while stalled; a transaction-level
//                model predicts stall length, bus request, write-back and
//                error pulse, checked every cycle by one compare process.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int T = 4;

    typedef struct {
        bit          valid;
        bit          is_ld;
        bit          is_st;
        bit          rw;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic [4:0]  rdn;
        int          R;      // REQ cycles with ready low before acceptance
        int          L;      // cycles between acceptance and response
        bit          err;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_read, mem_write, mem_reg_write;
    logic [31:0] mem_alu_out, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [4:0]  mem_rd;
    logic [31:0] mem_fwd_data;
    logic        mem_stall;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        bus_err;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.RSP_TIMEOUT(T)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_valid     (mem_valid),
        .mem_alu_out   (mem_alu_out),
        .mem_wdata     (mem_wdata),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_funct3    (mem_funct3),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .mem_fwd_data  (mem_fwd_data),
        .mem_stall     (mem_stall),
        .dbus          (bus),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .bus_err       (bus_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- model ----------------
    function automatic int size_of(input bit is_st, input logic [2:0] f3);
        if (f3 == 3'b000) return 1;
        if (f3 == 3'b001) return 2;
        if (!is_st && f3 == 3'b100) return 1;
        if (!is_st && f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          sz;
        logic [31:0] v;
        sz = size_of(1'b0, f3);
        if (sz == 4) return rd;
        if (sz == 1) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] st_strb(input int sz, input logic [31:0] a);
        int s;
        if (sz == 1)      s = 1 << a[1:0];
        else if (sz == 2) s = 3 << (2 * a[1]);
        else              s = 15;
        return s[3:0];
    endfunction

    function automatic logic [31:0] st_data(input int sz, input logic [31:0] d);
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // ---------------- expectations for the compare process ----------------
    bit          chk_en = 1'b0;
    logic        e_stall, e_req, e_we, e_wb_we, e_err;
    logic [31:0] e_addr, e_wdata, e_wb_data, e_fwd;
    logic [3:0]  e_strb;
    logic [4:0]  e_rd;
    int          cnt_stall;
    logic [3:0]  cap_strb;
    logic [31:0] cap_wdata;

    // Result of the previous instruction, visible in MEM/WB next cycle.
    logic        pw_we = 1'b0, pw_err = 1'b0;
    logic [4:0]  pw_rd = 5'd0;
    logic [31:0] pw_data = 32'd0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_stall", {31'd0, mem_stall}, {31'd0, e_stall});
            chk("mem_fwd_data", mem_fwd_data, e_fwd);
            chk("req_valid", {31'd0, bus.dbus_req_valid}, {31'd0, e_req});
            if (e_req) begin
                chk("dbus_addr", bus.dbus_addr, e_addr);
                chk("dbus_we", {31'd0, bus.dbus_we}, {31'd0, e_we});
                chk("dbus_wstrb", {28'd0, bus.dbus_wstrb}, {28'd0, e_strb});
                if (e_we) chk("dbus_wdata", bus.dbus_wdata, e_wdata);
            end
            chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e_wb_we});
            if (e_wb_we) begin
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e_rd});
                chk("wb_data", wb_data, e_wb_data);
            end
            chk("bus_err", {31'd0, bus_err}, {31'd0, e_err});
            if (mem_stall) cnt_stall++;
            if (bus.dbus_req_valid) begin
                cap_strb  = bus.dbus_wstrb;
                cap_wdata = bus.dbus_wdata;
            end
        end
    end

    // Holds one instruction in EX/MEM until the model says it leaves,
    // acting as the bus slave with ready/response delays from the record.
    task automatic run_instr(input instr_t t);
        bit          mop, trap, tmo, rdy, rsp, reqv, acc;
        int          sz, S, Q, N, rq, wc;
        logic [31:0] a;
        a    = t.alu;
        mop  = t.valid && (t.is_ld || t.is_st);
        sz   = size_of(t.is_st, t.f3);
        trap = 1'b0;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        trap = mop && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
`endif
        tmo = mop && !trap && (t.R + t.L + 2 > T + 1);
        if (!mop || trap) S = 0;
        else if (tmo)     S = T + 1;
        else              S = t.R + t.L + 2;
        Q = t.R + 1;
        if (tmo && Q > T + 1) Q = T + 1;
        if (!mop || trap) Q = 0;
        N   = S + 1;
        rq  = 0;
        wc  = 0;
        acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            mem_valid     = t.valid;
            mem_read      = t.is_ld;
            mem_write     = t.is_st;
            mem_reg_write = t.rw;
            mem_funct3    = t.f3;
            mem_alu_out   = a;
            mem_wdata     = t.wd;
            mem_rd        = t.rdn;
            reqv = bus.dbus_req_valid;
            rdy  = reqv && (rq == t.R);
            rsp  = acc && (wc == t.L);
            bus.dbus_req_ready = rdy;
            bus.dbus_rsp_valid = rsp;
            bus.dbus_rsp_err   = rsp && t.err;
            bus.dbus_rdata     = t.rdata;
            e_stall   = (i < S);
            e_fwd     = a;
            e_req     = (i >= 1) && (i <= Q);
            e_addr    = a & 32'hFFFF_FFFC;
            e_we      = t.is_st;
            e_strb    = t.is_st ? st_strb(sz, a) : 4'h0;
            e_wdata   = st_data(sz, t.wd);
            e_wb_we   = (i == 0) ? pw_we : 1'b0;
            e_rd      = pw_rd;
            e_wb_data = pw_data;
            e_err     = (i == 0) ? pw_err : 1'b0;
            chk_en    = 1'b1;
            @(posedge clk);
            #1;
            if (rsp) acc = 1'b0;
            else if (acc) wc++;
            if (rdy) begin
                acc = 1'b1;
                wc  = 0;
            end else if (reqv) begin
                rq++;
            end
        end
        pw_err = trap || tmo || (mop && t.err);
        if (!mop) begin
            pw_we   = t.valid && t.rw;
            pw_rd   = t.rdn;
            pw_data = a;
        end else if (pw_err || t.is_st) begin
            pw_we = 1'b0;
        end else begin
            pw_we   = t.rw;
            pw_rd   = t.rdn;
            pw_data = load_val(t.f3, a, t.rdata);
        end
    endtask

    function automatic instr_t mk(input bit v, input bit ld, input bit st, input bit rw,
                                  input logic [2:0] f3, input logic [31:0] alu,
                                  input logic [31:0] wd, input logic [31:0] rdata,
                                  input logic [4:0] rdn, input int R, input int L,
                                  input bit err);
        instr_t t;
        t.valid = v;  t.is_ld = ld;  t.is_st = st;  t.rw = rw;
        t.f3 = f3;    t.alu = alu;   t.wd = wd;     t.rdata = rdata;
        t.rdn = rdn;  t.R = R;       t.L = L;       t.err = err;
        return t;
    endfunction

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_reg_write = 1'b0;
        mem_alu_out = 32'd0; mem_wdata = 32'd0; mem_funct3 = 3'd0; mem_rd = 5'd0;
        bus.dbus_req_ready = 1'b0; bus.dbus_rsp_valid = 1'b0;
        bus.dbus_rsp_err = 1'b0;   bus.dbus_rdata = 32'd0;
        e_stall = 0; e_req = 0; e_we = 0; e_wb_we = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_wb_data = 0; e_fwd = 0; e_strb = 0; e_rd = 0;
        cnt_stall = 0; cap_strb = 0; cap_wdata = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("reset wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("reset wb_data", wb_data, 32'd0);
        chk("reset bus_err", {31'd0, bus_err}, 32'd0);
        chk("reset req_valid", {31'd0, bus.dbus_req_valid}, 32'd0);
        chk("reset mem_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1'b0;

        // SW: ready on first REQ cycle, response two cycles after acceptance
        cnt_stall = 0;
        run_instr(mk(1, 0, 1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 2, 0));
        chk("SW stall cycles", cnt_stall, 32'd4);
        chk("SW strb", {28'd0, cap_strb}, 32'h0000_000F);

        run_instr(mk(1, 0, 1, 0, 3'b000, 32'h103, 32'h0000_00AB, 0, 0, 0, 0, 0));
        chk("SB strb", {28'd0, cap_strb}, 32'h0000_0008);
        chk("SB wdata", cap_wdata, 32'hABAB_ABAB);
        chk("SB wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

        run_instr(mk(1, 1, 0, 1, 3'b000, 32'h101, 0, 32'h0000_8000, 5'd3, 0, 0, 0));
        chk("LB wb_data", wb_data, 32'hFFFF_FF80);
        run_instr(mk(1, 1, 0, 1, 3'b100, 32'h101, 0, 32'h0000_8000, 5'd3, 1, 1, 0));
        chk("LBU wb_data", wb_data, 32'h0000_0080);

        cnt_stall = 0;
        run_instr(mk(1, 0, 0, 1, 3'b000, 32'h55, 0, 0, 5'd7, 0, 0, 0));
        chk("ADD wb_data", wb_data, 32'h55);
        chk("ADD wb_rd", {27'd0, wb_rd}, 32'd7);
        chk("ADD stall cycles", cnt_stall, 32'd0);

        run_instr(mk(1, 1, 0, 1, 3'b010, 32'h200, 0, 32'h1234_5678, 5'd9, 10, 0, 0));
        chk("timeout bus_err", {31'd0, bus_err}, 32'd1);
        chk("timeout wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        run_instr(mk(1, 1, 0, 1, 3'b010, 32'h204, 0, 32'h1234_5678, 5'd9, 0, 0, 1));
        chk("rsp_err bus_err", {31'd0, bus_err}, 32'd1);
        chk("rsp_err wb_reg_write", {31'd0, wb_reg_write}, 32'd0);

        // Reset while in WAIT, then a stray response must not write back.
        chk_en = 1'b0;
        mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_reg_write = 1'b1;
        mem_funct3 = 3'b010; mem_alu_out = 32'h300; mem_rd = 5'd4;
        bus.dbus_req_ready = 1'b1; bus.dbus_rsp_valid = 1'b0; bus.dbus_rsp_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.dbus_req_ready = 1'b0;
        chk("WAIT stall before rst", {31'd0, mem_stall}, 32'd1);
        rst = 1'b1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst req_valid", {31'd0, bus.dbus_req_valid}, 32'd0);
        chk("rst mem_stall", {31'd0, mem_stall}, 32'd0);
        bus.dbus_rsp_valid = 1'b1;
        bus.dbus_rdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.dbus_rsp_valid = 1'b0;
        chk("late rsp wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        chk("late rsp req_valid", {31'd0, bus.dbus_req_valid}, 32'd0);
        pw_we  = 1'b0;
        pw_err = 1'b0;

        for (int n = 0; n < 300; n++) begin
            instr_t t;
            int     k;
            k       = $urandom_range(0, 9);
            t.valid = ($urandom_range(0, 9) != 0);
            t.is_ld = (k >= 3 && k <= 6);
            t.is_st = (k >= 7);
            t.rw    = ($urandom_range(0, 3) != 0);
            t.f3    = 3'($urandom_range(0, 7));
            t.alu   = $urandom;
            t.wd    = $urandom;
            t.rdata = $urandom;
            t.rdn   = 5'($urandom_range(0, 31));
            t.R     = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
            t.L     = $urandom_range(0, 3);
            t.err   = ($urandom_range(0, 9) == 0);
            run_instr(t);
        end
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
